// File: rtl/fifo_rd_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_serializer_pkg
// Purpose  : State encoding and width helper shared by the read serializer.
// Revision : 1.0
// ============================================================================
package fifo_rd_serializer_pkg;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    // Ceiling log2 that never returns 0, so a 1-beat ratio still gets a 1-bit index.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_rd_slice_mux.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_slice_mux
// Purpose  : Selects one OUT_WIDTH slice of a wide word by slice index.
// Revision : 1.0
// ============================================================================
module fifo_rd_slice_mux #(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 64,
    parameter int SEL_WIDTH = 3
) (
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic [SEL_WIDTH-1:0] i_sel,
    output logic [OUT_WIDTH-1:0] o_data
);

    localparam int c_RATIO = IN_WIDTH / OUT_WIDTH;

    logic [OUT_WIDTH-1:0] w_slices [c_RATIO];

    generate
        for (genvar gi = 0; gi < c_RATIO; gi++) begin : g_slice
            assign w_slices[gi] = i_data[gi*OUT_WIDTH +: OUT_WIDTH];
        end
    endgenerate

    // Out-of-range indices (non power-of-two ratios) read as zero.
    always_comb begin
        o_data = '0;
        for (int i = 0; i < c_RATIO; i++) begin
            if (i_sel == SEL_WIDTH'(i)) begin
                o_data = w_slices[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_rd_serializer.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_serializer
// Purpose  : Pops wide words from a show-ahead FIFO and emits them as
//            LSB-first narrow beats on a valid/ready stream.
// Revision : 1.0
// ============================================================================
module fifo_rd_serializer
    import fifo_rd_serializer_pkg::*;
#(
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 read_clk,
    input  logic                 read_rst,
    input  logic [IN_WIDTH-1:0]  fifo_data_out,
    input  logic                 fifo_empty,
    output logic                 fifo_read_en,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    input  logic                 flush,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    localparam int RATIO    = IN_WIDTH / OUT_WIDTH;
    localparam int c_BEAT_W = clog2_min1(RATIO);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(RATIO - 1);

    generate
        if ((OUT_WIDTH < 1) || (IN_WIDTH < OUT_WIDTH) || (IN_WIDTH % OUT_WIDTH != 0)) begin : g_width_err
            $error("fifo_rd_serializer: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
        end
    endgenerate

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [c_BEAT_W-1:0]   w_beat_nxt;
    logic [IN_WIDTH-1:0]   r_hold;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic                  w_accept;
    logic                  w_load;

    assign m_valid  = (r_state == SEND);
    assign busy     = m_valid;
    assign m_last   = m_valid && (r_beat == c_LAST_BEAT);
    assign w_accept = m_valid && m_ready;
    assign word_cnt = r_word_cnt;

    // A new word is taken when idle, or in the same cycle the final beat leaves.
    assign w_load       = !fifo_empty && !flush && ((r_state == EMPTY) || (w_accept && m_last));
    assign fifo_read_en = w_load && !read_rst;

    fifo_rd_slice_mux #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SEL_WIDTH (c_BEAT_W)
    ) u_slice_mux (
        .i_data (r_hold),
        .i_sel  (r_beat),
        .o_data (m_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_beat_nxt  = '0;
        end else if (w_load) begin
            w_state_nxt = SEND;
            w_beat_nxt  = '0;
        end else if (w_accept && m_last) begin
            w_state_nxt = EMPTY;
        end else if (w_accept) begin
            w_beat_nxt  = r_beat + c_BEAT_W'(1);
        end
    end

    always_ff @(posedge read_clk or posedge read_rst) begin
        if (read_rst) begin
            r_state    <= EMPTY;
            r_beat     <= '0;
            r_hold     <= '0;
            r_word_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_load) begin
                r_hold     <= fifo_data_out;
                r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_serializer
// Purpose  : Self-checking bench: vector table, flush/reset sequences and a
//            randomized run against a beat-queue reference model.
// Revision : 1.0
// ============================================================================
module tb_fifo_rd_serializer;

    localparam int IW = 32;
    localparam int OW = 8;
    localparam int CW = 16;
    localparam int NB = IW / OW;

    logic          read_clk;
    logic          read_rst;
    logic [IW-1:0] fifo_data_out;
    logic          fifo_empty;
    logic          fifo_read_en;
    logic [OW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          flush;
    logic          busy;
    logic [CW-1:0] word_cnt;

    fifo_rd_serializer #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .CNT_WIDTH (CW)
    ) dut (
        .read_clk      (read_clk),
        .read_rst      (read_rst),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .fifo_read_en  (fifo_read_en),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .flush         (flush),
        .busy          (busy),
        .word_cnt      (word_cnt)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    typedef struct {
        logic          push;
        logic [IW-1:0] pdata;
        logic          ready;
        logic          flsh;
        logic          exp_rd;
        logic          exp_valid;
        logic [OW-1:0] exp_data;
        logic          exp_last;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    logic [IW-1:0] fq[$];
    logic [OW-1:0] mq[$];
    vec_t          vecs[$];
    int            n_checks = 0;
    int            n_errors = 0;

    function automatic vec_t v(input logic push, input logic [IW-1:0] pdata,
                               input logic ready, input logic flsh,
                               input logic rd, input logic vld,
                               input logic [OW-1:0] dat, input logic lst,
                               input logic [CW-1:0] cnt);
        vec_t r;
        r.push = push; r.pdata = pdata; r.ready = ready; r.flsh = flsh;
        r.exp_rd = rd; r.exp_valid = vld; r.exp_data = dat; r.exp_last = lst;
        r.exp_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Present the FIFO head to the DUT and let combinational outputs settle.
    task automatic settle();
        fifo_empty    = (fq.size() == 0);
        fifo_data_out = (fq.size() == 0) ? '0 : fq[0];
        #1;
    endtask

    // Cross one rising edge; the FIFO pops if the DUT asked for it.
    task automatic advance();
        logic rd;
        rd = fifo_read_en;
        @(posedge read_clk);
        #1;
        if (rd && fq.size() > 0) void'(fq.pop_front());
        settle();
    endtask

    task automatic check_all(input string tag, input logic rd, input logic vld,
                             input logic [OW-1:0] dat, input logic lst, input logic [CW-1:0] cnt);
        chk({tag, ".rd_en"}, 32'(fifo_read_en), 32'(rd));
        chk({tag, ".valid"}, 32'(m_valid), 32'(vld));
        chk({tag, ".busy"},  32'(busy), 32'(vld));
        chk({tag, ".last"},  32'(m_last), 32'(lst));
        chk({tag, ".cnt"},   32'(word_cnt), 32'(cnt));
        if (vld) chk({tag, ".data"}, 32'(m_data), 32'(dat));
    endtask

    initial begin
        logic          exp_rd;
        logic [CW-1:0] mcnt;
        logic [IW-1:0] w;

        m_ready = 1'b0;
        flush   = 1'b0;
        read_rst = 1'b1;
        settle();
        chk("reset.valid", 32'(m_valid), 0);
        chk("reset.last",  32'(m_last), 0);
        chk("reset.busy",  32'(busy), 0);
        chk("reset.data",  32'(m_data), 0);
        chk("reset.cnt",   32'(word_cnt), 0);
        chk("reset.rd_en", 32'(fifo_read_en), 0);
        @(posedge read_clk);
        #1;
        read_rst = 1'b0;
        settle();

        // single word
        vecs.push_back(v(1, 32'h44332211, 1, 0, 1, 0, 8'h00, 0, 0));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h11, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h22, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h33, 0, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h44, 1, 1));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 1));
        // two words back to back
        vecs.push_back(v(1, 32'h44332211, 1, 0, 1, 0, 8'h00, 0, 1));
        vecs.push_back(v(1, 32'h88776655, 1, 0, 0, 1, 8'h11, 0, 2));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h22, 0, 2));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h33, 0, 2));
        vecs.push_back(v(0, 0, 1, 0, 1, 1, 8'h44, 1, 2));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h55, 0, 3));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h66, 0, 3));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h77, 0, 3));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h88, 1, 3));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 3));
        // backpressure, next word queued while stalled on the last beat
        vecs.push_back(v(1, 32'hDDCCBBAA, 0, 0, 1, 0, 8'h00, 0, 3));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'hAA, 0, 4));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 8'hBB, 0, 4));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 8'hBB, 0, 4));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'hBB, 0, 4));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 8'hCC, 0, 4));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'hCC, 0, 4));
        vecs.push_back(v(1, 32'h04030201, 0, 0, 0, 1, 8'hDD, 1, 4));
        vecs.push_back(v(0, 0, 0, 0, 0, 1, 8'hDD, 1, 4));
        vecs.push_back(v(0, 0, 1, 0, 1, 1, 8'hDD, 1, 4));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h01, 0, 5));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h02, 0, 5));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h03, 0, 5));
        vecs.push_back(v(0, 0, 1, 0, 0, 1, 8'h04, 1, 5));
        // FIFO stays empty
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 5));
        vecs.push_back(v(0, 0, 0, 0, 0, 0, 8'h00, 0, 5));
        vecs.push_back(v(0, 0, 1, 0, 0, 0, 8'h00, 0, 5));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].push) fq.push_back(vecs[i].pdata);
            m_ready = vecs[i].ready;
            flush   = vecs[i].flsh;
            settle();
            check_all($sformatf("vec%0d", i), vecs[i].exp_rd, vecs[i].exp_valid,
                      vecs[i].exp_data, vecs[i].exp_last, vecs[i].exp_cnt);
            advance();
        end

        // flush after the second beat is accepted
        fq.push_back(32'h14131211);
        fq.push_back(32'h24232221);
        m_ready = 1'b1;
        settle();
        check_all("fl.load", 1, 0, 8'h00, 0, 5);
        advance();
        check_all("fl.b0", 0, 1, 8'h11, 0, 6);
        advance();
        check_all("fl.b1", 0, 1, 8'h12, 0, 6);
        advance();
        flush = 1'b1;
        settle();
        check_all("fl.flush", 0, 1, 8'h13, 0, 6);
        advance();
        flush = 1'b0;
        settle();
        check_all("fl.after", 1, 0, 8'h00, 0, 6);
        advance();
        for (int b = 0; b < NB; b++) begin
            check_all($sformatf("fl.next%0d", b), 0, 1, 8'h21 + 8'(b), (b == NB - 1), 7);
            advance();
        end

        // asynchronous reset mid-word
        fq.push_back(32'h34333231);
        fq.push_back(32'h44434241);
        settle();
        check_all("rs.load", 1, 0, 8'h00, 0, 7);
        advance();
        advance();
        advance();
        check_all("rs.b2", 0, 1, 8'h33, 0, 8);
        #2;
        read_rst = 1'b1;
        #1;
        check_all("rs.async", 0, 0, 8'h00, 0, 0);
        chk("rs.data", 32'(m_data), 0);
        advance();
        check_all("rs.held", 0, 0, 8'h00, 0, 0);
        read_rst = 1'b0;
        settle();
        check_all("rs.resume", 1, 0, 8'h00, 0, 0);
        advance();
        check_all("rs.first", 0, 1, 8'h41, 0, 1);

        // randomized run against the beat-queue model
        read_rst = 1'b1;
        fq.delete();
        mq.delete();
        mcnt = '0;
        m_ready = 1'b0;
        flush = 1'b0;
        advance();
        read_rst = 1'b0;
        settle();
        for (int c = 0; c < 3000; c++) begin
            if (fq.size() < 6 && ($urandom % 3) != 0) fq.push_back($urandom);
            m_ready = (($urandom % 4) != 0);
            flush   = (($urandom % 40) == 0);
            settle();
            exp_rd = (fq.size() > 0) && !flush &&
                     ((mq.size() == 0) || (m_ready && mq.size() == 1));
            check_all($sformatf("rnd%0d", c), exp_rd, (mq.size() > 0),
                      (mq.size() > 0) ? mq[0] : 8'h00, (mq.size() == 1), mcnt);
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() > 0 && m_ready) void'(mq.pop_front());
                if (exp_rd) begin
                    w = fq[0];
                    for (int b = 0; b < NB; b++) mq.push_back(w[b*OW +: OW]);
                end
            end
            if (exp_rd) mcnt = mcnt + 1'b1;
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
